// File: rtl/dvp_pattern_tx.sv
// DVP camera-bus test pattern transmitter.
// Emits RGB565 frames one byte per clock: VSYNC lines, back porch, active lines, front porch.
// Every state lasts a whole number of lines of LINE = 2*H_PIXEL + H_BLANK clocks.
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   enable              level request; a frame, once started, always completes
//   pattern_sel[1:0]    0 solid, 1 ramp, 2 colour bars, 3 checker (latched at frame start)
//   color_i[15:0]       RGB565 colour for the solid pattern (latched at frame start)
//   cam_vsync/cam_href  frame sync / line valid
//   cam_data[7:0]       pixel byte, high byte first; 0 while cam_href is low
//   frame_done          one-cycle pulse on the final cycle of each frame
//   busy                high whenever not idle
//   frame_cnt[15:0]     completed frames, wraps
module dvp_pattern_tx #(
  parameter int unsigned H_PIXEL   = 1024,
  parameter int unsigned V_PIXEL   = 768,
  parameter int unsigned H_BLANK   = 64,
  parameter int unsigned VS_LINES  = 4,
  parameter int unsigned VBP_LINES = 16,
  parameter int unsigned VFP_LINES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] color_i,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int unsigned Line     = 2 * H_PIXEL + H_BLANK;
  localparam int unsigned ActBytes = 2 * H_PIXEL;
  localparam int unsigned MaxA     = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
  localparam int unsigned MaxB     = (V_PIXEL > VFP_LINES) ? V_PIXEL : VFP_LINES;
  localparam int unsigned MaxLines = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned HcntW    = $clog2(Line + 1);
  localparam int unsigned LineW    = $clog2(MaxLines + 1);
  // Line index of the final line of a frame within its state.
  localparam int unsigned EndLine  = (VFP_LINES != 0) ? VFP_LINES - 1 : V_PIXEL - 1;

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

  localparam state_e EndState = (VFP_LINES != 0) ? StVfp : StActive;

  state_e            state_q, state_d;
  logic [HcntW-1:0]  hcnt_q, hcnt_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [1:0]        pat_q, pat_d;
  logic [15:0]       col_q, col_d;

  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic [LineW-1:0]  last_line;
  logic [2:0]        bar_idx;
  logic [15:0]       pix;

  // Position sequencing: (state, line, hcnt) names the cycle currently on the bus.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    line_d  = line_q;
    pat_d   = pat_q;
    col_d   = col_q;

    unique case (state_q)
      StVsync:  last_line = LineW'(VS_LINES - 1);
      StVbp:    last_line = LineW'(VBP_LINES - 1);
      StActive: last_line = LineW'(V_PIXEL - 1);
      StVfp:    last_line = LineW'(VFP_LINES - 1);
      default:  last_line = '0;
    endcase

    if (state_q == StIdle) begin
      if (enable) begin
        state_d = StVsync;
        hcnt_d  = '0;
        line_d  = '0;
      end
    end else if (hcnt_q == HcntW'(Line - 1)) begin
      hcnt_d = '0;
      if (line_q == last_line) begin
        line_d = '0;
        unique case (state_q)
          StVsync:  state_d = (VBP_LINES != 0) ? StVbp : StActive;
          StVbp:    state_d = StActive;
          StActive: state_d = (VFP_LINES != 0) ? StVfp : (enable ? StVsync : StIdle);
          StVfp:    state_d = enable ? StVsync : StIdle;
          default:  state_d = StIdle;
        endcase
      end else begin
        line_d = line_q + 1'b1;
      end
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end

    // Pattern settings are frozen for the whole frame from its first VSYNC cycle.
    if (state_d == StVsync && state_q != StVsync) begin
      pat_d = pattern_sel;
      col_d = color_i;
    end
  end

  // Output values for the next bus cycle, derived from the next position.
  always_comb begin
    bar_idx = 3'(((32'(hcnt_d) >> 1) * 32'd8) / H_PIXEL);

    unique case (pat_q)
      2'd0: pix = col_q;
      2'd1: pix = 16'((32'(hcnt_d) >> 1) & 32'h7FF);
      2'd2: begin
        unique case (bar_idx)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      // x[5] is hcnt[6]; y[5] is line[5].
      default: pix = ((((32'(hcnt_d) >> 6) ^ (32'(line_d) >> 5)) & 32'd1) != 32'd0) ?
                     16'hFFFF : 16'h0000;
    endcase

    vsync_d = (state_d == StVsync);
    busy_d  = (state_d != StIdle);
    href_d  = (state_d == StActive) && (hcnt_d < HcntW'(ActBytes));
    data_d  = href_d ? (hcnt_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    done_d  = (state_d == EndState) && (hcnt_d == HcntW'(Line - 1)) &&
              (line_d == LineW'(EndLine));
    frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hcnt_q      <= '0;
      line_q      <= '0;
      pat_q       <= '0;
      col_q       <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      line_q      <= line_d;
      pat_q       <= pat_d;
      col_q       <= col_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx with a tiny frame (LINE = 11, frame = 55 cycles).
// A frame-position model pushes the expected bus state every clock; a monitor pops and
// compares on the falling edge.
module tb_dvp_pattern_tx;

  localparam int HP    = 4;
  localparam int VP    = 2;
  localparam int HB    = 3;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int LINE  = 2 * HP + HB;
  localparam int FRAME = (VS + VBP + VP + VFP) * LINE;

  typedef struct packed {
    logic        vs;
    logic        href;
    logic [7:0]  data;
    logic        done;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] color_i;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  dvp_pattern_tx #(
    .H_PIXEL   (HP),
    .V_PIXEL   (VP),
    .H_BLANK   (HB),
    .VS_LINES  (VS),
    .VBP_LINES (VBP),
    .VFP_LINES (VFP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .color_i     (color_i),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected bus state for frame position pos (0 = first VSYNC cycle).
  function automatic exp_t frame_exp(input int pos, input logic [1:0] pat,
                                     input logic [15:0] col, input logic [15:0] cnt);
    exp_t        e;
    int          ln;
    int          h;
    int          x;
    int          y;
    logic [15:0] pix;
    ln     = pos / LINE;
    h      = pos % LINE;
    x      = h / 2;
    e      = '0;
    e.busy = 1'b1;
    e.cnt  = cnt;
    e.vs   = (ln < VS);
    e.done = (pos == FRAME - 1);
    if (ln >= VS + VBP && ln < VS + VBP + VP && h < 2 * HP) begin
      y = ln - VS - VBP;
      case (pat)
        2'd0:    pix = col;
        2'd1:    pix = 16'(x & 'h7FF);
        2'd2:    pix = bars[(x * 8) / HP];
        default: pix = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
      e.href = 1'b1;
      e.data = (h % 2 == 1) ? pix[7:0] : pix[15:8];
    end
    return e;
  endfunction

  // Reference model: tracks frame position and pushes one expectation per clock.
  int          mpos;
  logic [1:0]  mpat;
  logic [15:0] mcol;
  logic [15:0] mcnt;

  initial begin
    exp_t e;
    mpos = -1;
    mpat = '0;
    mcol = '0;
    mcnt = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mpos = -1;
        mcnt = '0;
      end else if (mpos < 0 || mpos == FRAME - 1) begin
        if (enable) begin
          mpos = 0;
          mpat = pattern_sel;
          mcol = color_i;
        end else begin
          mpos = -1;
        end
      end else begin
        mpos++;
      end
      if (mpos == FRAME - 1) mcnt = mcnt + 16'd1;
      if (mpos < 0) begin
        e     = '0;
        e.cnt = mcnt;
      end else begin
        e = frame_exp(mpos, mpat, mcol, mcnt);
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("vsync", 32'(cam_vsync), 32'(e.vs));
        check_eq("href", 32'(cam_href), 32'(e.href));
        check_eq("data", 32'(cam_data), 32'(e.data));
        check_eq("frame_done", 32'(frame_done), 32'(e.done));
        check_eq("busy", 32'(busy), 32'(e.busy));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst_n       = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    color_i     = 16'h0000;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(4);
    check_eq("idle_cnt", 32'(frame_cnt), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Solid colour, single-cycle enable pulse.
    pattern_sel = 2'd0;
    color_i     = 16'hABCD;
    pulse_enable();
    wait_cycles(60);
    check_eq("solid_cnt", 32'(frame_cnt), 32'd1);
    check_eq("solid_busy_after", 32'(busy), 32'd0);

    // Ramp; switching to checker mid-frame must not take effect.
    pattern_sel = 2'd1;
    pulse_enable();
    wait_cycles(28);
    pattern_sel = 2'd3;
    color_i     = 16'h1234;
    wait_cycles(35);

    // Colour bars then checker.
    pattern_sel = 2'd2;
    pulse_enable();
    wait_cycles(60);
    pattern_sel = 2'd3;
    pulse_enable();
    wait_cycles(60);
    check_eq("patterns_cnt", 32'(frame_cnt), 32'd4);

    // Three back-to-back frames; enable dropped during the third frame's active lines.
    pattern_sel = 2'd1;
    enable      = 1'b1;
    wait_cycles(2 * FRAME + 25);
    enable = 1'b0;
    wait_cycles(40);
    check_eq("b2b_cnt", 32'(frame_cnt), 32'd7);
    check_eq("b2b_idle", 32'(busy), 32'd0);

    // Reset mid-frame during ACTIVE, then a full restart.
    pattern_sel = 2'd0;
    color_i     = 16'h5A3C;
    pulse_enable();
    wait_cycles(25);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_href", 32'(cam_href), 32'd0);
    wait_cycles(5);
    pulse_enable();
    wait_cycles(60);
    check_eq("restart_cnt", 32'(frame_cnt), 32'd1);

    // Counter wrap: preload 65535 while idle, then run one frame.
    @(posedge clk);
    #1;
    dut.frame_cnt_q = 16'hFFFF;
    mcnt = 16'hFFFF;
    e = exp_q.pop_back();
    e.cnt = 16'hFFFF;
    exp_q.push_back(e);
    @(negedge clk);
    pulse_enable();
    wait_cycles(60);
    check_eq("wrap_cnt", 32'(frame_cnt), 32'd0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_pattern_tx.md
DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

Interface
REQ-001 Parameter H_PIXEL, 1024, active pixels per line (RGB565, 2 bytes each).
REQ-002 Parameter V_PIXEL, 768, active lines per frame.
REQ-003 Parameter H_BLANK, 64, blank clock cycles appended to every line.
REQ-004 Parameter VS_LINES, 4, lines with cam_vsync high.
REQ-005 Parameter VBP_LINES, 16, blank lines after vsync.
REQ-006 Parameter VFP_LINES, 8, blank lines after the last active line.
REQ-007 clk  in  1  single clock; all logic on rising edge; one clock = one DVP byte.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 enable  in  1  request frame generation; level-sensitive.
REQ-010 pattern_sel  in  2  0 solid, 1 ramp, 2 colour bars, 3 checker.
REQ-011 color_i  in  16  RGB565 colour for solid pattern.
REQ-012 cam_vsync  out  1  frame sync, active high.
REQ-013 cam_href  out  1  line valid, high only during active bytes.
REQ-014 cam_data  out  8  DVP byte; 0 whenever cam_href low.
REQ-015 frame_done  out  1  one-cycle pulse at end of each frame.
REQ-016 busy  out  1  high while a frame is in progress.
REQ-017 frame_cnt  out  16  completed-frame count, wraps.

Function
REQ-018 The block SHALL implement states IDLE, VSYNC, VBP, ACTIVE, VFP, each spanning whole lines of LINE = 2*H_PIXEL+H_BLANK cycles, counted by hcnt (0..LINE-1) and a per-state line counter.
REQ-019 Transitions SHALL be: IDLE->VSYNC when enable sampled high; VSYNC->VBP after VS_LINES; VBP->ACTIVE after VBP_LINES; ACTIVE->VFP after V_PIXEL; VFP->VSYNC if enable high on the last VFP cycle, else IDLE.
REQ-020 A zero VBP_LINES or VFP_LINES SHALL skip that state.
REQ-021 All outputs SHALL be registered; cam_vsync and busy SHALL rise in the cycle after enable is first sampled high in IDLE.
REQ-022 cam_vsync SHALL be high exactly VS_LINES*LINE consecutive cycles per frame.
REQ-023 In ACTIVE, cam_href SHALL be high for hcnt 0..2*H_PIXEL-1 and low for the H_BLANK cycles.
REQ-024 Pixel x = hcnt/2, y = active-line index; even hcnt SHALL carry pixel[15:8], odd hcnt pixel[7:0].
REQ-025 Patterns: solid = color_i; ramp = {5'b0, x[10:0]}; bars = table[x*8/H_PIXEL] with white, yellow, cyan, green, magenta, red, blue, black (FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000); checker = (x[5]^y[5]) ? FFFF : 0000.
REQ-026 pattern_sel and color_i SHALL be latched on entry to VSYNC; changes mid-frame SHALL have no effect until the next frame.
REQ-027 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes through VFP, then IDLE.
REQ-028 Back-to-back frames SHALL have no gap: the cycle after the last VFP cycle is VSYNC line 0, hcnt 0.
REQ-029 frame_done SHALL pulse on the last cycle of the last VFP line (last ACTIVE line if VFP_LINES=0); frame_cnt SHALL increment in that same cycle, 65535 wraps to 0.
REQ-030 busy SHALL be low only in IDLE; it stays high across back-to-back frames.
REQ-031 Total frame length SHALL be (VS_LINES+VBP_LINES+V_PIXEL+VFP_LINES)*LINE cycles.

Reset
REQ-032 While rst_n is low at a clock edge, state SHALL become IDLE, counters 0, and cam_vsync, cam_href, cam_data, frame_done, busy, frame_cnt SHALL be 0 from the next cycle.
REQ-033 Reset mid-frame SHALL abandon the frame without frame_done; after release, generation restarts at VSYNC line 0 only when enable is sampled high.

Verification (H_PIXEL=4, V_PIXEL=2, H_BLANK=3, VS=1, VBP=1, VFP=1; LINE=11, frame=55)
REQ-034 enable pulsed high one cycle from IDLE -> vsync high 11 cycles, 2 href bursts of 8 cycles separated by 3 low cycles, frame_done at cycle 55, frame_cnt=1, busy low after.
REQ-035 pattern_sel=0, color_i=16'hABCD -> every active byte pair is AB, CD; cam_data=0 in blank cycles.
REQ-036 pattern_sel=1 -> bytes 00,00,00,01,00,02,00,03 on each active line; pattern_sel changed to 3 mid-frame -> ramp persists until next frame.
REQ-037 enable held high for 3 frames, dropped during frame 3 ACTIVE -> 165 contiguous cycles, vsync rising every 55 cycles, frame_cnt=3, then IDLE.
REQ-038 rst_n low for 1 cycle during ACTIVE -> all outputs 0 next cycle, no frame_done, frame_cnt=0; restart produces full 55-cycle frame.
REQ-039 frame_cnt forced/run to 65535, one more frame -> frame_cnt=0 with frame_done pulse.
